// File: rtl/gerador_tabela_verdade.sv
// gerador_tabela_verdade
// Truth-table sweeper for a small combinational gate. On start it steps the
// gate input through every combination, holds each one HOLD_CYCLES cycles,
// samples the gate output on the last held cycle and compares it with
// EXPECTED_MASK. It reports pass/fail, a mismatch count and the first
// failing vector.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   synchronous active-low reset
//   start      in   begin a sweep (looked at only in IDLE)
//   stim       out  vector driven to the gate (stim[1]->a, stim[0]->b for 2 inputs)
//   dut_y      in   gate output under test
//   busy       out  high while vectors are being driven
//   done       out  one-cycle pulse when a sweep completes
//   pass       out  last completed sweep had zero mismatches
//   err_count  out  mismatching vectors in the current/last sweep
//   fail_valid out  at least one mismatch recorded
//   fail_idx   out  stim value of the first mismatch
//   state_dbg  out  current FSM state (0 IDLE, 1 DRIVE, 2 DONE)
//
// Handshake: start is a request sampled only in IDLE; once accepted, busy
// stays high for exactly 2**N_INPUTS*HOLD_CYCLES cycles, then done pulses for
// one cycle. Requests made while busy or during done are dropped, not queued.
module gerador_tabela_verdade #(
  parameter int                      N_INPUTS      = 2,
  parameter int                      HOLD_CYCLES   = 10,
  parameter logic [2**N_INPUTS-1:0]  EXPECTED_MASK = 4'b1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [N_INPUTS-1:0] stim,
  input  logic                dut_y,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count,
  output logic                fail_valid,
  output logic [N_INPUTS-1:0] fail_idx,
  output logic [1:0]          state_dbg
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]       HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [N_INPUTS-1:0] STIM_LAST = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [CW-1:0]         hold_cnt, hold_next;
  logic [N_INPUTS-1:0]   stim_next;
  logic [N_INPUTS:0]     err_next;
  logic                  fail_valid_next;
  logic [N_INPUTS-1:0]   fail_idx_next;
  logic                  pass_next;
  logic                  mismatch;

  assign mismatch  = (dut_y != EXPECTED_MASK[stim]);
  assign busy      = (state == DRIVE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      stim       <= '0;
      hold_cnt   <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      pass       <= 1'b0;
    end else begin
      state      <= state_next;
      stim       <= stim_next;
      hold_cnt   <= hold_next;
      err_count  <= err_next;
      fail_valid <= fail_valid_next;
      fail_idx   <= fail_idx_next;
      pass       <= pass_next;
    end
  end

  always_comb begin
    state_next      = state;
    stim_next       = stim;
    hold_next       = hold_cnt;
    err_next        = err_count;
    fail_valid_next = fail_valid;
    fail_idx_next   = fail_idx;
    pass_next       = pass;
    case (state)
      IDLE: begin
        stim_next = '0;
        if (start) begin
          state_next      = DRIVE;
          hold_next       = '0;
          err_next        = '0;
          fail_valid_next = 1'b0;
          fail_idx_next   = '0;
          pass_next       = 1'b0;
        end
      end
      DRIVE: begin
        if (hold_cnt == HOLD_LAST) begin
          // Last held cycle: the gate has settled, so judge this vector.
          if (mismatch) begin
            err_next = err_count + 1'b1;
            if (!fail_valid) begin
              fail_valid_next = 1'b1;
              fail_idx_next   = stim;
            end
          end
          hold_next = '0;
          if (stim == STIM_LAST) begin
            state_next = DONE;
            stim_next  = '0;
          end else begin
            stim_next = stim + 1'b1;
          end
        end else begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      DONE: begin
        stim_next  = '0;
        state_next = IDLE;
        // err_count is final here, so pass is valid from the first IDLE cycle.
        pass_next  = (err_count == '0);
      end
      default: begin
        state_next = IDLE;
        stim_next  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gerador_tabela_verdade.sv
// Bench for gerador_tabela_verdade: a 2-input instance with a selectable gate
// model (AND, OR, stuck-at-1) and a 3-input, 1-cycle-hold instance with a
// 3-input AND. Expected sweep results are pushed into queues by the driver
// and popped by monitor processes when done pulses.
module tb_gerador_tabela_verdade;

  localparam int H  = 10;
  localparam int NV = 4;
  localparam int H3  = 1;
  localparam int NV3 = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] stim;
  logic       dut_y;
  logic       busy, done, pass, fail_valid;
  logic [2:0] err_count;
  logic [1:0] fail_idx;
  logic [1:0] state_dbg;

  logic       start3;
  logic [2:0] stim3;
  logic       y3;
  logic       busy3, done3, pass3, fail_valid3;
  logic [3:0] err_count3;
  logic [2:0] fail_idx3;
  logic [1:0] state_dbg3;

  logic [1:0] mode;  // 0 AND, 1 OR, 2 stuck at 1

  gerador_tabela_verdade dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_y(dut_y),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_idx(fail_idx), .state_dbg(state_dbg)
  );

  gerador_tabela_verdade #(.N_INPUTS(3), .HOLD_CYCLES(1), .EXPECTED_MASK(8'h80)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stim(stim3), .dut_y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
    .fail_valid(fail_valid3), .fail_idx(fail_idx3), .state_dbg(state_dbg3)
  );

  // ---------------- clock / reset / gate models ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (mode)
      2'd0:    dut_y = stim[1] & stim[0];
      2'd1:    dut_y = stim[1] | stim[0];
      default: dut_y = 1'b1;
    endcase
  end
  assign y3 = &stim3;

  // ---------------- scoreboard ----------------
  logic [6:0] exp_q[$];   // {pass, fail_valid, fail_idx, err_count}
  logic [8:0] exp3_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- monitor, 2-input instance ----------------
  bit         sweep_on = 1'b0;
  bit         pend = 1'b0;
  int         start_edge = 0;
  logic [5:0] rest;
  logic [6:0] cur_exp;

  always @(negedge clk) begin
    int k;
    k = cyc - start_edge;
    if (pend) begin
      pend = 1'b0;
      check("result", 32'({pass, rest}), 32'(cur_exp));
    end
    if (done) begin
      if (!sweep_on) check("unexpected_done", 32'd1, 32'd0);
      else begin
        check("done_latency", 32'(k), 32'(NV*H));
        check("busy_in_done", 32'(busy), 32'd0);
        if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
        else begin
          cur_exp = exp_q.pop_front();
          rest    = {fail_valid, fail_idx, err_count};
          pend    = 1'b1;
        end
        sweep_on = 1'b0;
      end
    end else if (sweep_on && k < NV*H) begin
      check("busy", 32'(busy), 32'd1);
      check("stim", 32'(stim), 32'(k / H));
    end
  end

  // ---------------- monitor, 3-input instance ----------------
  bit         sweep3_on = 1'b0;
  bit         pend3 = 1'b0;
  int         start3_edge = 0;
  logic [7:0] rest3;
  logic [8:0] cur3_exp;

  always @(negedge clk) begin
    int k;
    k = cyc - start3_edge;
    if (pend3) begin
      pend3 = 1'b0;
      check("result3", 32'({pass3, rest3}), 32'(cur3_exp));
    end
    if (done3) begin
      if (!sweep3_on) check("unexpected_done3", 32'd1, 32'd0);
      else begin
        check("done_latency3", 32'(k), 32'(NV3*H3));
        if (exp3_q.size() == 0) check("queue_empty3", 32'd1, 32'd0);
        else begin
          cur3_exp = exp3_q.pop_front();
          rest3    = {fail_valid3, fail_idx3, err_count3};
          pend3    = 1'b1;
        end
        sweep3_on = 1'b0;
      end
    end else if (sweep3_on && k < NV3*H3) begin
      check("busy3", 32'(busy3), 32'd1);
      check("stim3", 32'(stim3), 32'(k / H3));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_sweep(input logic [6:0] exp);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    start_edge = cyc;
    exp_q.push_back(exp);
    sweep_on   = 1'b1;
  endtask

  task automatic start_sweep3(input logic [8:0] exp);
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3      = 1'b0;
    start3_edge = cyc;
    exp3_q.push_back(exp);
    sweep3_on   = 1'b1;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sweep_on || pend) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sweep_on || pend) begin
      check("timeout", 32'd1, 32'd0);
      sweep_on = 1'b0;
      pend     = 1'b0;
      exp_q.delete();
    end
  endtask

  task automatic wait_idle3();
    int t = 0;
    while ((sweep3_on || pend3) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sweep3_on || pend3) begin
      check("timeout3", 32'd1, 32'd0);
      sweep3_on = 1'b0;
      pend3     = 1'b0;
      exp3_q.delete();
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    mode   = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_stim", 32'(stim), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_fvalid", 32'(fail_valid), 32'd0);
    check("rst_fidx", 32'(fail_idx), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    rst_n = 1'b1;

    // 1: real AND gate -> clean pass
    mode = 2'd0;
    start_sweep(7'b1_0_00_000);
    wait_idle();

    // 2: OR gate -> vectors 1 and 2 mismatch
    mode = 2'd1;
    start_sweep(7'b0_1_01_010);
    wait_idle();
    repeat (5) @(negedge clk);
    check("hold_err", 32'(err_count), 32'd2);
    check("hold_fidx", 32'(fail_idx), 32'd1);
    check("hold_pass", 32'(pass), 32'd0);

    // 3: stuck at 1 -> vectors 0,1,2 mismatch; then AND clears results
    mode = 2'd2;
    start_sweep(7'b0_1_00_011);
    wait_idle();
    mode = 2'd0;
    start_sweep(7'b1_0_00_000);
    wait_idle();

    // 4: start re-pulsed at +15 and +39 is ignored
    start_sweep(7'b1_0_00_000);
    repeat (14) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (23) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("no_restart", 32'(busy), 32'd0);

    // 5: reset at +20 mid-sweep
    mode = 2'd2;
    start_sweep(7'b0_1_00_011);
    repeat (19) @(negedge clk);
    check("pre_reset_err", 32'(err_count), 32'd1);
    rst_n    = 1'b0;
    sweep_on = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_stim", 32'(stim), 32'd0);
    check("mid_rst_err", 32'(err_count), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_fvalid", 32'(fail_valid), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_after_rst", 32'(busy), 32'd0);
    mode = 2'd0;
    start_sweep(7'b1_0_00_000);
    wait_idle();

    // 6: 3-input AND, one cycle per vector
    start_sweep3(9'b1_0_000_0000);
    wait_idle3();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
